mem_port_arbiter: RTL and testbench

Shares the single-port data/instruction memory between the fetch stage and the load/store path (LW, SW, LBU, SB). Data accesses take priority, with a starvation guard for fetch. The block sequences fixed-latency reads and single-cycle writes, and performs byte-lane steering for SB and zero-extension for LBU. It sits between the fetch/execute stages and the memory macro, and replaces direct MemRead/MemWrite wiring to memory.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_byte_lane.sv | 20 ++
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and byte-enable constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: SB lane steering/replication on stores, LBU lane select and zero-extend on loads
module mem_byte_lane
  import mem_arb_pkg::*;
(
  input  logic        st_byte,
  input  logic        st_hi,
  input  logic [15:0] st_data,
  output logic [1:0]  st_be,
  output logic [15:0] st_wdata,
  input  logic        ld_byte,
  input  logic        ld_hi,
  input  logic [15:0] ld_raw,
  output logic [15:0] ld_data
);
  always_comb begin
    st_be = st_byte ? (st_hi ? BE_HI : BE_LO) : BE_WORD;
    st_wdata = st_byte ? {st_data[7:0], st_data[7:0]} : st_data;
    ld_data = ld_byte ? {8'h00, ld_hi ? ld_raw[15:8] : ld_raw[7:0]} : ld_raw;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, data first with a fetch starvation guard
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [2:0] LAT = 3'(MEM_LAT);
  state_t state;
  owner_t owner;
  logic [2:0] lat_cnt;
  logic [SW-1:0] starve;
  logic r_byte, r_hi, idle, pick_if, rd_gnt, done;
  logic [1:0] st_be;
  logic [DATA_W-1:0] st_wdata, ld_data;
  mem_byte_lane u_lane (
    .st_byte(d_byte),
    .st_hi(d_addr[0]),
    .st_data(d_wdata),
    .st_be(st_be),
    .st_wdata(st_wdata),
    .ld_byte(r_byte),
    .ld_hi(r_hi),
    .ld_raw(mem_rdata),
    .ld_data(ld_data)
  );
  // grants are decided combinationally so the winner reaches the memory in the same cycle
  always_comb begin
    idle = state == IDLE && !reset;
    pick_if = if_req && (!d_req || starve >= SMAX);
    if_gnt = idle && pick_if;
    d_gnt = idle && d_req && !pick_if;
    rd_gnt = if_gnt || (d_gnt && !d_we);
    mem_en = if_gnt || d_gnt;
    mem_we = d_gnt && d_we;
    mem_be = mem_we ? st_be : mem_en ? BE_WORD : 2'b00;
    mem_addr = d_gnt ? d_addr[ADDR_W-1:1] : if_gnt ? if_addr[ADDR_W-1:1] : '0;
    mem_wdata = mem_we ? st_wdata : '0;
    done = state == RD_WAIT && lat_cnt == 3'd1 && !reset;
    if_rvalid = done && owner == OWN_IF;
    d_rvalid = done && owner == OWN_D;
    if_rdata = if_rvalid ? mem_rdata : '0;
    d_rdata = d_rvalid ? ld_data : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_IF;
      lat_cnt <= '0;
      starve <= '0;
      r_byte <= 1'b0;
      r_hi <= 1'b0;
    end else begin
      starve <= (!if_req || if_gnt) ? '0 : (d_gnt && starve != SMAX) ? starve + 1'b1 : starve;
      if (state == IDLE) begin
        if (rd_gnt) begin
          state <= RD_WAIT;
          lat_cnt <= LAT;
          owner <= if_gnt ? OWN_IF : OWN_D;
          r_byte <= d_gnt && d_byte;
          r_hi <= if_gnt ? if_addr[0] : d_addr[0];
        end
      end else begin
        lat_cnt <= lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, directed corner sequences and a randomized scoreboard run
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic reset;
  logic if_req, d_req, d_we, d_byte;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [1:0] mem_be;
  logic [14:0] mem_addr;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .STARVE_MAX(3)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // latency-sweep instances: fetch-only, constant read data
  logic sw_req = 1'b0;
  logic [15:0] sw_zero = 16'h0000, sw_rdata = 16'h1234;
  logic l1_if_gnt, l1_if_rvalid, l1_d_gnt, l1_d_rvalid, l1_mem_en, l1_mem_we, l1_busy;
  logic l4_if_gnt, l4_if_rvalid, l4_d_gnt, l4_d_rvalid, l4_mem_en, l4_mem_we, l4_busy;
  logic [15:0] l1_if_rdata, l1_d_rdata, l1_mem_wdata, l4_if_rdata, l4_d_rdata, l4_mem_wdata;
  logic [1:0] l1_mem_be, l4_mem_be;
  logic [14:0] l1_mem_addr, l4_mem_addr;
  mem_port_arbiter #(.MEM_LAT(1)) u_l1 (
    .clk(clk), .reset(reset),
    .if_req(sw_req), .if_addr(sw_zero), .if_gnt(l1_if_gnt), .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_byte(1'b0), .d_addr(sw_zero), .d_wdata(sw_zero),
    .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_be(l1_mem_be), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(sw_rdata), .busy(l1_busy)
  );
  mem_port_arbiter #(.MEM_LAT(4)) u_l4 (
    .clk(clk), .reset(reset),
    .if_req(sw_req), .if_addr(sw_zero), .if_gnt(l4_if_gnt), .if_rvalid(l4_if_rvalid), .if_rdata(l4_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_byte(1'b0), .d_addr(sw_zero), .d_wdata(sw_zero),
    .d_gnt(l4_d_gnt), .d_rvalid(l4_d_rvalid), .d_rdata(l4_d_rdata),
    .mem_en(l4_mem_en), .mem_we(l4_mem_we), .mem_be(l4_mem_be), .mem_addr(l4_mem_addr),
    .mem_wdata(l4_mem_wdata), .mem_rdata(sw_rdata), .busy(l4_busy)
  );

  // memory macro model: 64 words, fixed LAT-cycle read pipeline
  logic [15:0] mem [64];
  logic mem_init = 1'b0;
  logic [2:0] pv = '0;
  logic [2:0][5:0] pa;
  function automatic logic [15:0] pat(int w);
    logic [7:0] b;
    b = 8'(w);
    return w == 8 ? 16'hA5C3 : {b ^ 8'h3C, b + 8'h40};
  endfunction
  always_ff @(posedge clk) begin
    pv <= {pv[1:0], mem_en & ~mem_we};
    pa <= {pa[1:0], mem_addr[5:0]};
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else if (mem_en && mem_we) begin
      if (mem_be[0]) mem[mem_addr[5:0]][7:0] <= mem_wdata[7:0];
      if (mem_be[1]) mem[mem_addr[5:0]][15:8] <= mem_wdata[15:8];
    end
  end
  assign mem_rdata = pv[2] ? mem[pa[2]] : 16'hDEAD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  typedef struct {
    logic ir; logic [15:0] ia; logic dr, we, by; logic [15:0] da, dw;
    logic eig, edg; logic [1:0] ebe; logic [14:0] ea; logic [15:0] ewd; logic [1:0] erv; logic [15:0] erd;
  } vec_t;
  vec_t tv[12];
  typedef struct {int due; logic who_d; logic [15:0] data;} rd_t;
  rd_t q[$];
  rd_t r;
  logic [7:0] sh [128];
  logic [1:0] rv, erv, ebe;
  logic [15:0] rd, erd, ewd, a, ia, da, dw, w;
  logic ip, dq, dwe, dby, eig, edg, wr;
  int pulses, lat, ifp, dpc, nf, st, g1, g4, p1, p4, n1, n4;

  initial begin
    tv[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, 15'h0008, 16'h0000, 2'b10, 16'hA5C3};
    tv[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, 1'b1, 2'b11, 15'h0008, 16'h0000, 2'b01, 16'h00A5};
    tv[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b1, 2'b11, 15'h0008, 16'h0000, 2'b01, 16'h00C3};
    tv[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0021, 16'h0077, 1'b0, 1'b1, 2'b10, 15'h0010, 16'h7777, 2'b00, 16'h0000};
    tv[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 2'b11, 15'h0010, 16'h0000, 2'b01, 16'h7750};
    tv[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h12AB, 1'b0, 1'b1, 2'b01, 15'h0010, 16'hABAB, 2'b00, 16'h0000};
    tv[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0021, 16'h0000, 1'b0, 1'b1, 2'b11, 15'h0010, 16'h0000, 2'b01, 16'h77AB};
    tv[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0030, 16'hBEEF, 1'b0, 1'b1, 2'b11, 15'h0018, 16'hBEEF, 2'b00, 16'h0000};
    tv[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0031, 16'h0000, 1'b0, 1'b1, 2'b11, 15'h0018, 16'h0000, 2'b01, 16'h00BE};
    tv[9]  = '{1'b1, 16'h0040, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b1, 2'b11, 15'h0018, 16'h0000, 2'b01, 16'hBEEF};
    tv[10] = '{1'b1, 16'h0031, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, 15'h0018, 16'h0000, 2'b10, 16'hBEEF};
    tv[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00, 15'h0000, 16'h0000, 2'b00, 16'h0000};
    idle_in();
    reset = 1'b1;
    mem_init = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_ctl", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_be, busy}), 32'd0);
    chk("rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    chk("rst_mem", 32'({mem_addr, mem_wdata}), 32'd0);
    step();
    reset = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, busy}), 32'd0);
    step();

    for (int i = 0; i < 12; i++) begin
      if_req = tv[i].ir; if_addr = tv[i].ia; d_req = tv[i].dr; d_we = tv[i].we;
      d_byte = tv[i].by; d_addr = tv[i].da; d_wdata = tv[i].dw;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), 32'({if_gnt, d_gnt}), 32'({tv[i].eig, tv[i].edg}));
      chk($sformatf("vec%0d_mem_ctl", i), 32'({mem_en, mem_we, mem_be}),
          32'({tv[i].eig | tv[i].edg, tv[i].edg & tv[i].we, tv[i].ebe}));
      chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tv[i].ea));
      chk($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(tv[i].ewd));
      step();
      idle_in();
      pulses = 0; lat = 0; rv = '0; rd = '0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (if_rvalid || d_rvalid) begin
          pulses++; lat = k; rv = {if_rvalid, d_rvalid}; rd = if_rdata | d_rdata;
        end
      end
      step();
      chk($sformatf("vec%0d_rv_count", i), 32'(pulses), 32'(tv[i].erv != 2'b00));
      chk($sformatf("vec%0d_rv_who", i), 32'(rv), 32'(tv[i].erv));
      chk($sformatf("vec%0d_rv_lat", i), 32'(lat), tv[i].erv != 2'b00 ? 32'(LAT) : 32'd0);
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tv[i].erd));
    end

    // starvation guard: held fetch wins after three consecutive data grants
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b1; d_byte = 1'b0; d_addr = 16'h003E; d_wdata = 16'h5555;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("starve_gnt%0d", c), 32'({if_gnt, d_gnt}), c < 4 ? 32'd1 : c == 4 ? 32'd2 : 32'd0);
      step();
      if (c == 4) if_req = 1'b0;
    end
    idle_in();
    repeat (6) step();

    // reset one cycle into a fetch read aborts it
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    chk("rmr_if_gnt", 32'(if_gnt), 32'd1);
    step();
    reset = 1'b1;
    idle_in();
    @(negedge clk);
    chk("rmr_rv_in_reset", 32'({if_rvalid, d_rvalid}), 32'd0);
    step();
    reset = 1'b0;
    d_req = 1'b1; d_addr = 16'h0030;
    @(negedge clk);
    chk("rmr_busy", 32'(busy), 32'd0);
    chk("rmr_new_gnt", 32'({if_gnt, d_gnt}), 32'd1);
    step();
    idle_in();
    ifp = 0; dpc = 0; lat = 0; rd = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (if_rvalid) ifp++;
      if (d_rvalid) begin dpc++; lat = k; rd = d_rdata; end
    end
    step();
    chk("rmr_no_if_rvalid", 32'(ifp), 32'd0);
    chk("rmr_d_count", 32'(dpc), 32'd1);
    chk("rmr_d_lat", 32'(lat), 32'(LAT));
    chk("rmr_d_data", 32'(rd), 32'h0000BEEF);

    // back-to-back fetches at MEM_LAT 1 and 4
    g1 = -1; g4 = -1; p1 = -1; p4 = -1; n1 = 0; n4 = 0;
    sw_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (l1_if_gnt && g1 < 0) g1 = c;
      if (l4_if_gnt && g4 < 0) g4 = c;
      if (l1_if_rvalid) begin
        chk("lat1_spacing", 32'(c - (p1 < 0 ? g1 : p1)), p1 < 0 ? 32'd1 : 32'd2);
        chk("lat1_rdata", 32'(l1_if_rdata), 32'h1234);
        p1 = c; n1++;
      end
      if (l4_if_rvalid) begin
        chk("lat4_spacing", 32'(c - (p4 < 0 ? g4 : p4)), p4 < 0 ? 32'd4 : 32'd5);
        chk("lat4_rdata", 32'(l4_if_rdata), 32'h1234);
        p4 = c; n4++;
      end
    end
    step();
    sw_req = 1'b0;
    chk("lat1_count", 32'(n1), 32'd15);
    chk("lat4_count", 32'(n4), 32'd6);

    // randomized traffic against a cycle/byte-level reference
    mem_init = 1'b1;
    step();
    mem_init = 1'b0;
    for (int b = 0; b < 128; b++) begin
      w = pat(b / 2);
      sh[b] = b[0] ? w[15:8] : w[7:0];
    end
    ip = 1'b0; dq = 1'b0; nf = 0; st = 0; ia = '0; da = '0; dw = '0; dwe = 1'b0; dby = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if_req = ip; if_addr = ia; d_req = dq; d_we = dwe; d_byte = dby; d_addr = da; d_wdata = dw;
      @(negedge clk);
      eig = n >= nf && ip && (!dq || st >= 3);
      edg = n >= nf && dq && !eig;
      wr = edg && dwe;
      erv = 2'b00; erd = '0;
      if (q.size() > 0 && q[0].due == n) begin
        erv = q[0].who_d ? 2'b01 : 2'b10;
        erd = q[0].data;
        void'(q.pop_front());
      end
      a = eig ? ia : da;
      ebe = wr ? (dby ? (da[0] ? 2'b10 : 2'b01) : 2'b11) : (eig || edg) ? 2'b11 : 2'b00;
      ewd = wr ? (dby ? {dw[7:0], dw[7:0]} : dw) : 16'h0000;
      chk("rnd_gnt", 32'({if_gnt, d_gnt}), 32'({eig, edg}));
      chk("rnd_rvalid", 32'({if_rvalid, d_rvalid}), 32'(erv));
      chk("rnd_if_rdata", 32'(if_rdata), erv[1] ? 32'(erd) : 32'd0);
      chk("rnd_d_rdata", 32'(d_rdata), erv[0] ? 32'(erd) : 32'd0);
      chk("rnd_busy", 32'(busy), 32'(n < nf));
      chk("rnd_mem_ctl", 32'({mem_en, mem_we, mem_be}), 32'({eig | edg, wr, ebe}));
      chk("rnd_mem_addr", 32'(mem_addr), (eig || edg) ? 32'(a[15:1]) : 32'd0);
      chk("rnd_mem_wdata", 32'(mem_wdata), 32'(ewd));
      if (wr && dby) sh[da[6:0]] = dw[7:0];
      if (wr && !dby) begin
        sh[{da[6:1], 1'b0}] = dw[7:0];
        sh[{da[6:1], 1'b1}] = dw[15:8];
      end
      if (eig || (edg && !dwe)) begin
        r.due = n + LAT;
        r.who_d = edg;
        r.data = (edg && dby) ? {8'h00, sh[da[6:0]]} : {sh[{a[6:1], 1'b1}], sh[{a[6:1], 1'b0}]};
        q.push_back(r);
        nf = n + LAT + 1;
      end
      st = (!ip || eig) ? 0 : (edg && st < 3) ? st + 1 : st;
      if (eig) ip = 1'b0;
      if (edg) dq = 1'b0;
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1'b1;
        ia = 16'($urandom_range(0, 127));
      end
      if (!dq && $urandom_range(0, 2) != 0) begin
        dq = 1'b1;
        dwe = 1'($urandom_range(0, 1));
        dby = 1'($urandom_range(0, 1));
        da = 16'($urandom_range(0, 127));
        dw = 16'($urandom);
      end
      step();
    end
    idle_in();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
